// File: rtl/ap_sel_stack.sv
// Active-pointer select register with a LIFO of saved pointers (call/return style).
// Define AP_ONEHOT_EN to add a registered one-hot decode of ap_sel on port ap_onehot.
module ap_sel_stack #(
    parameter int SEL_W = 4,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] ap_set,
    input  logic             ap_load,
    input  logic             ap_push,
    input  logic             ap_pop,
    output logic [SEL_W-1:0] ap_sel,
    output logic [CW-1:0]    depth_cnt,
    output logic             full,
    output logic             empty,
    output logic             err
`ifdef AP_ONEHOT_EN
    ,
    output logic [(2**SEL_W)-1:0] ap_onehot
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } op_state_t;

    op_state_t        op_state;
    logic [SEL_W-1:0] stack [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push_ok;
    logic             pop_ok;
    logic             err_next;
    logic [SEL_W-1:0] sel_next;

    // Occupancy state is a pure function of depth_cnt, so it can never disagree with it.
    always_comb begin
        op_state = ST_PARTIAL;
        if (depth_cnt == '0)
            op_state = ST_EMPTY;
        else if (depth_cnt == CW'(DEPTH))
            op_state = ST_FULL;
    end

    assign full  = (op_state == ST_FULL);
    assign empty = (op_state == ST_EMPTY);

    assign wr_idx = AW'(depth_cnt);
    assign rd_idx = AW'(depth_cnt - CW'(1));

    // Simultaneous push and pop is treated as an error and does nothing.
    always_comb begin
        push_ok  = ap_push && !ap_pop && !full;
        pop_ok   = ap_pop && !ap_push && !empty;
        err_next = (ap_push && ap_pop)
                 || (ap_push && !ap_pop && full)
                 || (ap_pop && !ap_push && empty);
        sel_next = ap_sel;
        if (ap_push && ap_pop)
            sel_next = ap_sel;
        else if (ap_pop) begin
            if (pop_ok)
                sel_next = stack[rd_idx];
        end else if (ap_load)
            sel_next = ap_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_sel    <= '0;
            depth_cnt <= '0;
            err       <= 1'b0;
        end else begin
            ap_sel <= sel_next;
            err    <= err_next;
            if (push_ok)
                depth_cnt <= depth_cnt + CW'(1);
            else if (pop_ok)
                depth_cnt <= depth_cnt - CW'(1);
        end
    end

    // Slot storage is deliberately left unreset; a slot is only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            stack[wr_idx] <= ap_sel;
    end

`ifdef AP_ONEHOT_EN
    localparam int OH_W = 2**SEL_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ap_onehot <= OH_W'(1);
        else
            ap_onehot <= OH_W'(1) << sel_next;
    end
`endif

endmodule

// File: tb/tb_ap_sel_stack.sv
// Directed self-checking bench for ap_sel_stack (SEL_W=4, DEPTH=8).
// Checks the one-hot output too when AP_ONEHOT_EN is defined.
module tb_ap_sel_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ap_set = '0;
    logic       ap_load = 1'b0;
    logic       ap_push = 1'b0;
    logic       ap_pop = 1'b0;
    logic [3:0] ap_sel;
    logic [3:0] depth_cnt;
    logic       full;
    logic       empty;
    logic       err;
`ifdef AP_ONEHOT_EN
    logic [15:0] ap_onehot;
`endif

    int total = 0;
    int bad   = 0;

    ap_sel_stack #(.SEL_W(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ap_set    (ap_set),
        .ap_load   (ap_load),
        .ap_push   (ap_push),
        .ap_pop    (ap_pop),
        .ap_sel    (ap_sel),
        .depth_cnt (depth_cnt),
        .full      (full),
        .empty     (empty),
        .err       (err)
`ifdef AP_ONEHOT_EN
        ,
        .ap_onehot (ap_onehot)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge; outputs are read at the same point.
    task automatic drive(input logic pu, input logic po, input logic ld, input logic [3:0] s);
        ap_push = pu;
        ap_pop  = po;
        ap_load = ld;
        ap_set  = s;
        @(posedge clk);
        #1;
        ap_push = 1'b0;
        ap_pop  = 1'b0;
        ap_load = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (ap_sel !== 4'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0d want=0", ap_sel); end
        total++;
        if (depth_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_depth got=%0d want=0", depth_cnt); end
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags got e=%b f=%b err=%b want e=1 f=0 err=0", empty, full, err);
        end
`ifdef AP_ONEHOT_EN
        total++;
        if (ap_onehot !== 16'h0001) begin bad++; $display("[TB] FAIL reset_onehot got=%h want=0001", ap_onehot); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_load;
        for (int v = 0; v <= 8; v++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(v));
            total++;
            if (ap_sel !== 4'(v) || err !== 1'b0) begin
                bad++; $display("[TB] FAIL load_%0d got sel=%0d err=%b want sel=%0d err=0", v, ap_sel, err, v);
            end
`ifdef AP_ONEHOT_EN
            total++;
            if (ap_onehot !== (16'h0001 << v)) begin
                bad++; $display("[TB] FAIL load_onehot_%0d got=%h want=%h", v, ap_onehot, 16'h0001 << v);
            end
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 4'd3);
        total++;
        if (ap_sel !== 4'd8 || err !== 1'b0 || depth_cnt !== 4'd0) begin
            bad++; $display("[TB] FAIL idle_hold got sel=%0d err=%b depth=%0d want 8 0 0", ap_sel, err, depth_cnt);
        end
    endtask

    task automatic test_call_return;
        drive(1'b0, 1'b0, 1'b1, 4'd3);
        total++;
        if (ap_sel !== 4'd3 || depth_cnt !== 4'd0) begin
            bad++; $display("[TB] FAIL call_load got sel=%0d depth=%0d want 3 0", ap_sel, depth_cnt);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd5);
        total++;
        if (ap_sel !== 4'd5 || depth_cnt !== 4'd1 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL call_push got sel=%0d depth=%0d err=%b want 5 1 0", ap_sel, depth_cnt, err);
        end
        drive(1'b0, 1'b1, 1'b1, 4'd12);
        total++;
        if (ap_sel !== 4'd3 || depth_cnt !== 4'd0 || err !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("[TB] FAIL call_pop got sel=%0d depth=%0d err=%b empty=%b want 3 0 0 1", ap_sel, depth_cnt, err, empty);
        end
    endtask

    task automatic test_fill_drain;
        drive(1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(i));
            total++;
            if (ap_sel !== 4'(i) || depth_cnt !== 4'(i) || err !== 1'b0) begin
                bad++; $display("[TB] FAIL fill_%0d got sel=%0d depth=%0d err=%b want %0d %0d 0", i, ap_sel, depth_cnt, err, i, i);
            end
        end
        total++;
        if (full !== 1'b1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL full_flag got f=%b e=%b want f=1 e=0", full, empty); end
        drive(1'b1, 1'b0, 1'b1, 4'd9);
        total++;
        if (err !== 1'b1 || depth_cnt !== 4'd8 || ap_sel !== 4'd9) begin
            bad++; $display("[TB] FAIL push_full got err=%b depth=%0d sel=%0d want 1 8 9", err, depth_cnt, ap_sel);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_one_cycle got=%b want=0", err); end
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0);
            total++;
            if (ap_sel !== 4'(i) || depth_cnt !== 4'(i) || err !== 1'b0) begin
                bad++; $display("[TB] FAIL drain_%0d got sel=%0d depth=%0d err=%b want %0d %0d 0", i, ap_sel, depth_cnt, err, i, i);
            end
        end
        total++;
        if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL empty_flag got e=%b f=%b want e=1 f=0", empty, full); end
    endtask

    task automatic test_pop_empty;
        drive(1'b0, 1'b1, 1'b1, 4'd9);
        total++;
        if (err !== 1'b1 || ap_sel !== 4'd0 || empty !== 1'b1 || depth_cnt !== 4'd0) begin
            bad++; $display("[TB] FAIL pop_empty got err=%b sel=%0d empty=%b depth=%0d want 1 0 1 0", err, ap_sel, empty, depth_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL pop_empty_err_clear got=%b want=0", err); end
    endtask

    task automatic test_push_pop;
        drive(1'b1, 1'b0, 1'b1, 4'd6);
        drive(1'b1, 1'b0, 1'b1, 4'd11);
        total++;
        if (ap_sel !== 4'd11 || depth_cnt !== 4'd2) begin
            bad++; $display("[TB] FAIL pp_setup got sel=%0d depth=%0d want 11 2", ap_sel, depth_cnt);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd2);
        total++;
        if (err !== 1'b1 || ap_sel !== 4'd11 || depth_cnt !== 4'd2) begin
            bad++; $display("[TB] FAIL push_pop got err=%b sel=%0d depth=%0d want 1 11 2", err, ap_sel, depth_cnt);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        total++;
        if (ap_sel !== 4'd6 || depth_cnt !== 4'd1 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL push_pop_stack got sel=%0d depth=%0d err=%b want 6 1 0", ap_sel, depth_cnt, err);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 1'b0, 1'b1, 4'(i));
        total++;
        if (depth_cnt !== 4'd5 || ap_sel !== 4'd4) begin
            bad++; $display("[TB] FAIL mid_setup got depth=%0d sel=%0d want 5 4", depth_cnt, ap_sel);
        end
        ap_push = 1'b1;
        ap_load = 1'b1;
        ap_set  = 4'd13;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (ap_sel !== 4'd0 || depth_cnt !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_reset got sel=%0d depth=%0d empty=%b full=%b err=%b want 0 0 1 0 0", ap_sel, depth_cnt, empty, full, err);
        end
`ifdef AP_ONEHOT_EN
        total++;
        if (ap_onehot !== 16'h0001) begin bad++; $display("[TB] FAIL mid_reset_onehot got=%h want=0001", ap_onehot); end
`endif
        #1;
        ap_push = 1'b0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd7);
        total++;
        if (ap_sel !== 4'd7 || depth_cnt !== 4'd0 || empty !== 1'b1) begin
            bad++; $display("[TB] FAIL after_reset got sel=%0d depth=%0d empty=%b want 7 0 1", ap_sel, depth_cnt, empty);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_call_return;
        test_fill_drain;
        test_pop_empty;
        test_push_pop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
